// File: rtl/divider_recon_pkg.sv
// Shared types and constants for the sequential dividend reconstructor.
// The optional error path in divider_recon_seq is enabled by DIVIDER_RECON_ERR_EN.
package divider_recon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } recon_state_t;

   localparam int DIV_DW = 8;

   // Iteration counter width; a floor of one bit keeps degenerate widths legal.
   function automatic int recon_cnt_w(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

   localparam int DIV_CW = recon_cnt_w(DIV_DW);

endpackage

// File: rtl/divider_recon_absdiff.sv
// Combinational absolute difference |a - b| of two unsigned W-bit values.
// Used by divider_recon_seq only when DIVIDER_RECON_ERR_EN is defined.
module divider_recon_absdiff #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // Subtract the smaller operand from the larger so the result never wraps.
   always_comb begin
      y = {W{1'b0}};
      if (a >= b) begin
         y = a - b;
      end else begin
         y = b - a;
      end
   end

endmodule

// File: rtl/divider_recon_seq.sv
// Sequential dividend reconstructor: n_hat = q*d + r using a shift-and-add
// datapath that consumes one quotient bit per cycle (fixed DW-cycle latency).
// Optional feature macro: DIVIDER_RECON_ERR_EN adds n_ref / err / err_nz.
module divider_recon_seq
   import divider_recon_pkg::*;
#(
   parameter int DW = DIV_DW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [DW-1:0]   q,
   input  logic [DW-1:0]   d,
   input  logic [DW-1:0]   r,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] n_hat
`ifdef DIVIDER_RECON_ERR_EN
   ,
   input  logic [2*DW-1:0] n_ref,
   output logic [2*DW-1:0] err,
   output logic            err_nz
`endif
);

   localparam int             CW       = recon_cnt_w(DW);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   recon_state_t       state_r;
   recon_state_t       state_nxt_s;
   logic [2*DW-1:0]    acc_r;
   logic [2*DW-1:0]    mcand_r;
   logic [DW-1:0]      mplier_r;
   logic [CW-1:0]      cnt_r;
   logic [2*DW-1:0]    n_hat_r;
   logic [2*DW-1:0]    acc_sum_s;
   logic               accept_s;
   logic               last_s;
   logic               busy_s;
   logic               done_s;

   // Start is honoured only when no iteration is in flight; classify the last step.
   always_comb begin
      accept_s = 1'b0;
      last_s   = 1'b0;
      if ((state_r == IDLE) || (state_r == DONE)) begin
         accept_s = start;
      end else begin
         accept_s = 1'b0;
      end
      if ((state_r == RUN) && (cnt_r == CNT_LAST)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Conditional add of the shifted multiplicand for the current quotient bit.
   always_comb begin
      acc_sum_s = acc_r;
      if (mplier_r[0]) begin
         acc_sum_s = acc_r + mcand_r;
      end else begin
         acc_sum_s = acc_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic: RUN lasts DW cycles, DONE lasts one.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM output decode straight from the state register.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_r)
         IDLE: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
         RUN: begin
            busy_s = 1'b1;
            done_s = 1'b0;
         end
         DONE: begin
            busy_s = 1'b0;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

   assign busy  = busy_s;
   assign done  = done_s;
   assign n_hat = n_hat_r;

   // Shift-add datapath: load operands on accept, one iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_r    <= {(2*DW){1'b0}};
         mcand_r  <= {(2*DW){1'b0}};
         mplier_r <= {DW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else if (accept_s) begin
         acc_r    <= {{DW{1'b0}}, r};
         mcand_r  <= {{DW{1'b0}}, d};
         mplier_r <= q;
         cnt_r    <= {CW{1'b0}};
      end else if (state_r == RUN) begin
         acc_r    <= acc_sum_s;
         mcand_r  <= {mcand_r[2*DW-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[DW-1:1]};
         cnt_r    <= cnt_r + CNT_ONE;
      end else begin
         acc_r    <= acc_r;
         mcand_r  <= mcand_r;
         mplier_r <= mplier_r;
         cnt_r    <= cnt_r;
      end
   end

   // Result register: written only on the final iteration, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_hat_r <= {(2*DW){1'b0}};
      end else if (last_s) begin
         n_hat_r <= acc_sum_s;
      end else begin
         n_hat_r <= n_hat_r;
      end
   end

`ifdef DIVIDER_RECON_ERR_EN
   logic [2*DW-1:0] n_ref_r;
   logic [2*DW-1:0] err_r;
   logic            err_nz_r;
   logic [2*DW-1:0] diff_s;

   divider_recon_absdiff #(
      .W (2*DW)
   ) u_absdiff (
      .a (acc_sum_s),
      .b (n_ref_r),
      .y (diff_s)
   );

   // Reference dividend captured with the other operands at accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_ref_r <= {(2*DW){1'b0}};
      end else if (accept_s) begin
         n_ref_r <= n_ref;
      end else begin
         n_ref_r <= n_ref_r;
      end
   end

   // Error magnitude and nonzero flag, updated alongside n_hat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_r    <= {(2*DW){1'b0}};
         err_nz_r <= 1'b0;
      end else if (last_s) begin
         err_r    <= diff_s;
         err_nz_r <= |diff_s;
      end else begin
         err_r    <= err_r;
         err_nz_r <= err_nz_r;
      end
   end

   assign err    = err_r;
   assign err_nz = err_nz_r;
`endif

endmodule

// File: tb/tb_divider_recon_seq.sv
// Directed self-checking bench for divider_recon_seq with an expected-result queue.
module tb_divider_recon_seq;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    q;
   logic [7:0]    d;
   logic [7:0]    r;
   logic          busy;
   logic          done;
   logic [15:0]   n_hat;
`ifdef DIVIDER_RECON_ERR_EN
   logic [15:0]   n_ref;
   logic [15:0]   err;
   logic          err_nz;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [15:0]   sb_q[$];

   divider_recon_seq #(.DW(DW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .q      (q),
      .d      (d),
      .r      (r),
      .busy   (busy),
      .done   (done),
      .n_hat  (n_hat)
`ifdef DIVIDER_RECON_ERR_EN
      ,
      .n_ref  (n_ref),
      .err    (err),
      .err_nz (err_nz)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one start cycle and queue its expected result; operands are scrambled afterwards.
   task automatic issue(input logic [7:0] qi, input logic [7:0] di, input logic [7:0] ri,
                        input logic [15:0] exp);
      q = qi;
      d = di;
      r = ri;
      start = 1'b1;
      sb_q.push_back(exp);
      step();
      start = 1'b0;
      q = 8'($urandom);
      d = 8'($urandom);
      r = 8'($urandom);
   endtask

   // Step until done (bounded), checking latency, busy span and the popped result.
   task automatic wait_done(input string tag, input int inj);
      int          lat;
      int          busy_n;
      logic [15:0] exp;
      lat = 0;
      busy_n = 0;
      while ((done !== 1'b1) && (lat < 20)) begin
         if (busy === 1'b1) busy_n++;
         if (lat == inj) begin
            start = 1'b1;
            q = 8'd9;
            d = 8'd9;
            r = 8'd0;
         end
         step();
         start = 1'b0;
         lat++;
      end
      check({tag, " latency"}, lat, 8);
      check({tag, " busy cycles"}, busy_n, 8);
      check({tag, " busy low in done"}, {31'd0, busy}, 32'd0);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
      check({tag, " n_hat"}, {16'd0, n_hat}, {16'd0, exp});
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (done === 1'b1) n++;
      end
   endtask

   initial begin
      int          nd;
      logic [7:0]  rq;
      logic [7:0]  rd;
      logic [7:0]  rr;

      rst_n = 1'b0;
      start = 1'b0;
      q = 8'd0;
      d = 8'd0;
      r = 8'd0;
`ifdef DIVIDER_RECON_ERR_EN
      n_ref = 16'd0;
`endif
      step();
      step();
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset n_hat", {16'd0, n_hat}, 32'd0);
      rst_n = 1'b1;
      step();

      // Basic operation and hold afterwards
      issue(8'h0C, 8'h15, 8'h07, 16'h0103);
      wait_done("basic", -1);
      step();
      check("basic done one pulse", {31'd0, done}, 32'd0);
      step();
      step();
      check("basic idle busy", {31'd0, busy}, 32'd0);
      check("basic n_hat held", {16'd0, n_hat}, 32'h0103);

      // Extremes and zero operands
      issue(8'hFF, 8'hFF, 8'hFF, 16'hFF00);
      wait_done("max", -1);
      step();
      issue(8'h00, 8'hAB, 8'h05, 16'h0005);
      wait_done("q0", -1);
      step();
      issue(8'h80, 8'h01, 8'h00, 16'h0080);
      wait_done("q80", -1);
      step();
      issue(8'h37, 8'h00, 8'h2A, 16'h002A);
      wait_done("d0", -1);
      step();

      // Start while busy is ignored
      issue(8'd3, 8'd5, 8'd1, 16'h0010);
      wait_done("busy_start", 2);
      count_dones(12, nd);
      check("busy_start no second done", nd, 0);
      check("busy_start n_hat held", {16'd0, n_hat}, 32'h0010);

      // Back-to-back: new start in the DONE cycle
      issue(8'h0C, 8'h15, 8'h07, 16'h0103);
      wait_done("b2b first", -1);
      issue(8'd2, 8'd2, 8'd1, 16'h0005);
      check("b2b no idle gap", {31'd0, busy}, 32'd1);
      check("b2b n_hat held in run", {16'd0, n_hat}, 32'h0103);
      wait_done("b2b second", -1);
      step();

      // Random operands against the arithmetic model
      for (int i = 0; i < 4; i++) begin
         rq = 8'($urandom);
         rd = 8'($urandom);
         rr = 8'($urandom);
         issue(rq, rd, rr, 16'(16'(rq) * 16'(rd) + 16'(rr)));
         wait_done("random", -1);
         step();
      end

      // Reset in the middle of an operation
      q = 8'hFF;
      d = 8'hFF;
      r = 8'h00;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset done", {31'd0, done}, 32'd0);
      check("midreset n_hat", {16'd0, n_hat}, 32'd0);
      rst_n = 1'b1;
      count_dones(15, nd);
      check("midreset no done", nd, 0);

`ifdef DIVIDER_RECON_ERR_EN
      n_ref = 16'h0105;
      issue(8'h0C, 8'h15, 8'h07, 16'h0103);
      n_ref = 16'($urandom);
      wait_done("err ne", -1);
      check("err value", {16'd0, err}, 32'h0002);
      check("err_nz set", {31'd0, err_nz}, 32'd1);
      step();
      n_ref = 16'h0103;
      issue(8'h0C, 8'h15, 8'h07, 16'h0103);
      n_ref = 16'($urandom);
      wait_done("err eq", -1);
      check("err zero", {16'd0, err}, 32'd0);
      check("err_nz clear", {31'd0, err_nz}, 32'd0);
      step();
`endif

      check("scoreboard empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divider_recon_seq.md
Name: divider_recon_seq

Overview:
Sequential inverse of the array divider. Rebuilds the dividend from a divider result as n_hat = q*d + r, using a shift-and-add datapath that handles one quotient bit per cycle.
Sits beside the approximate divider rows in the error-characterisation flow. Each (q, r) pair produced for a given d is mapped back to dividend space so accuracy can be measured against the original n.

Parameters:
DW, 8, operand width of q, d and r; n_hat is 2*DW bits wide.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when busy=0
q  input  DW  quotient to reconstruct from
d  input  DW  divisor
r  input  DW  remainder
busy  output  1  high while iterations are running
done  output  1  one-cycle pulse marking n_hat valid
n_hat  output  2*DW  reconstructed dividend, held until the next accepted start completes

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0; done=0; n_hat=0; all internal registers cleared. Reset mid-RUN abandons the operation and produces no done.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, go to RUN.
  - RUN: stays for exactly DW edges, then goes to DONE.
  - DONE: lasts one cycle. If start=1 in this cycle, go to RUN; otherwise go to IDLE.
- Start acceptance: in IDLE or DONE with start=1, latch:
  - acc = zero-extended r
  - mcand = zero-extended d
  - mplier = q
  - cnt = 0
- Start while busy=1 is ignored, with no queuing.
- RUN iteration, one per edge:
  - if mplier[0]=1, acc = acc + mcand (2*DW-bit add)
  - mcand shifts left by 1
  - mplier shifts right by 1
  - cnt increments
  - on the edge where cnt = DW-1, also load n_hat with the final acc value and enter DONE.
- Latency is fixed and independent of operand values, with no early exit when mplier becomes 0.
  - With start sampled at edge E0, done=1 during the cycle after edge E0+DW.
  - n_hat becomes valid in that same cycle.
- Width rule: max result is (2^DW-1)^2 + (2^DW-1) = 2^(2DW) - 2^DW, so the sum fits in 2*DW bits. No overflow handling is needed.
- busy=1 exactly in RUN. done=1 exactly in DONE.
- n_hat changes only at entry to DONE. It stays stable through IDLE and through the next RUN.
- Inputs q, d and r are not required to be stable after the accepting edge.
- d=0: n_hat = r. q=0: n_hat = r.

Optional Feature:
Macro DIVIDER_RECON_ERR_EN.
- Defined:
  - adds input n_ref [2*DW-1:0], latched with the other operands at start acceptance
  - adds output err [2*DW-1:0] = |n_hat - n_ref|, registered and updated in the same cycle as n_hat, reset value 0
  - adds output err_nz [1], high when err != 0, updated and reset with err
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package divider_recon_pkg holds:
  - state enum recon_state_t {IDLE, RUN, DONE}
  - default width constant DIV_DW = 8
  - localparam helper for the counter width, $clog2(DW)
- One natural sub-module: divider_recon_absdiff. It is a combinational 2*DW-bit absolute difference, instantiated only under DIVIDER_RECON_ERR_EN.
- The FSM and the shift-add datapath stay in the top module.

Test Plan:
- Basic: reset, then start with q=0x0C, d=0x15, r=0x07. Expect busy=1 for 8 cycles, then done pulse with n_hat=0x0103 (12*21+7=259). n_hat is held afterwards.
- Extremes: q=0xFF, d=0xFF, r=0xFF gives n_hat=0xFF00. q=0x00, d=0xAB, r=0x05 gives n_hat=0x0005. q=0x80, d=0x01, r=0x00 gives n_hat=0x0080. Latency is always 8.
- Start during busy: accept q=3, d=5, r=1. At cycle 3 pulse start with q=9, d=9, r=0. Expect a single done with n_hat=0x0010 and no second done.
- Back-to-back: assert start in the DONE cycle with q=2, d=2, r=1. Expect done after 8 more cycles with n_hat=0x0005, and no IDLE gap.
- Reset mid-op: accept q=0xFF, d=0xFF, r=0, then drop rst_n at cycle 4. Expect busy=0, done=0, n_hat=0; done never pulses for that operation.
- With DIVIDER_RECON_ERR_EN: q=0x0C, d=0x15, r=0x07, n_ref=0x0105 gives err=0x0002 and err_nz=1. With n_ref=0x0103, expect err=0 and err_nz=0.
